// File: rtl/axi_wdata_tx.sv
// -----------------------------------------------------------------------------
// axi_wdata_tx
//   AXI3-style W-channel transmitter. Burst descriptors (id, beats-1, user)
//   are queued in a small FIFO and a separate stream of data words is turned
//   into W beats carrying the descriptor's id/user, with wlast on the final
//   beat of every burst. Single clock domain.
//
// Optional feature (compile-time macro):
//   AXI_WDATA_TX_STALL_CNT_EN - adds output stall_cnt[15:0], a saturating
//   count of cycles in which a W beat is offered but not accepted.
//
// Parameters:
//   CMD_DEPTH   descriptor FIFO depth (power of two, >= 2)
//
// Ports:
//   tx_clk, txreset            clock, async active-high reset
//   in_cid/in_clen/in_cuser    descriptor id, beats-1, user bits
//   in_cvalid / out_cready     descriptor handshake
//   in_wdata/in_wstrb          data word and byte strobes
//   in_dvalid / out_dready     data word handshake
//   out_wid/out_wdata/out_wstrb/out_wuser/out_wlast   W beat payload
//   out_mwvalid / in_mwready   W beat handshake
//   out_busy                   burst active, beat pending or FIFO non-empty
//   stall_cnt                  (macro only) saturating stall-cycle counter
// -----------------------------------------------------------------------------
module axi_wdata_tx #(
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic        tx_clk,
  input  logic        txreset,
  input  logic [3:0]  in_cid,
  input  logic [3:0]  in_clen,
  input  logic [1:0]  in_cuser,
  input  logic        in_cvalid,
  output logic        out_cready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_dvalid,
  output logic        out_dready,
  output logic [3:0]  out_wid,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_wstrb,
  output logic [1:0]  out_wuser,
  output logic        out_wlast,
  output logic        out_mwvalid,
  input  logic        in_mwready,
  output logic        out_busy
`ifdef AXI_WDATA_TX_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned USER_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [USER_W-1:0] user;
  } cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Descriptor FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  cmd_t             cmd_in;
  cmd_t             head;

  state_t              state_q;
  logic [ID_W-1:0]     cur_id_q;
  logic [LEN_W-1:0]    cur_len_q;
  logic [USER_W-1:0]   cur_user_q;
  logic [LEN_W-1:0]    beat_cnt_q;

  logic [ID_W-1:0]     wid_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [USER_W-1:0]   wuser_q;
  logic                wlast_q;
  logic                wvalid_q;

  logic                out_slot_free;
  logic                load;
  logic                last_beat;

  assign fifo_full  = (count_q == CNT_W'(CMD_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Reset gates the ready so nothing is accepted while the block is held.
  assign out_cready = ~fifo_full & ~txreset;
  assign push       = in_cvalid & out_cready;
  // The IDLE state is the only consumer of the FIFO head.
  assign pop        = (state_q == IDLE) & ~fifo_empty;

  assign cmd_in = '{id: in_cid, len: in_clen, user: in_cuser};
  assign head   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; simultaneous push+pop leaves count as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer/occupancy registers.
  always_ff @(posedge tx_clk or posedge txreset) begin
    if (txreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge tx_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat sequencing
  // ---------------------------------------------------------------------------
  // The output register can accept a new beat when empty or draining this cycle.
  assign out_slot_free = ~wvalid_q | in_mwready;
  assign out_dready    = (state_q == SEND) & out_slot_free;
  assign load          = in_dvalid & out_dready;
  assign last_beat     = (beat_cnt_q == cur_len_q);

  // Burst FSM: IDLE pops a descriptor, SEND counts beats until cur_len.
  always_ff @(posedge tx_clk or posedge txreset) begin
    if (txreset) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      cur_user_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_id_q   <= head.id;
            cur_len_q  <= head.len;
            cur_user_q <= head.user;
            beat_cnt_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (load) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // W output register; payload holds after a drain so only valid drops.
  always_ff @(posedge tx_clk or posedge txreset) begin
    if (txreset) begin
      wid_q    <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wuser_q  <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
    end else if (load) begin
      wid_q    <= cur_id_q;
      wdata_q  <= in_wdata;
      wstrb_q  <= in_wstrb;
      wuser_q  <= cur_user_q;
      wlast_q  <= last_beat;
      wvalid_q <= 1'b1;
    end else if (in_mwready) begin
      wvalid_q <= 1'b0;
    end
  end

  assign out_wid     = wid_q;
  assign out_wdata   = wdata_q;
  assign out_wstrb   = wstrb_q;
  assign out_wuser   = wuser_q;
  assign out_wlast   = wlast_q;
  assign out_mwvalid = wvalid_q;
  assign out_busy    = (state_q == SEND) | wvalid_q | ~fifo_empty;

`ifdef AXI_WDATA_TX_STALL_CNT_EN
  // Saturating count of offered-but-not-taken beat cycles.
  logic [15:0] stall_cnt_q;

  always_ff @(posedge tx_clk or posedge txreset) begin
    if (txreset) begin
      stall_cnt_q <= '0;
    end else if (wvalid_q && !in_mwready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_wdata_tx.sv
// Testbench for axi_wdata_tx: table-driven single-beat sequence, directed
// multi-cycle sequences and randomized traffic checked against a stream model.
module tb_axi_wdata_tx;

  localparam int unsigned DEPTH = 4;

  logic        tx_clk;
  logic        txreset;
  logic [3:0]  in_cid;
  logic [3:0]  in_clen;
  logic [1:0]  in_cuser;
  logic        in_cvalid;
  logic        out_cready;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;
  logic        in_dvalid;
  logic        out_dready;
  logic [3:0]  out_wid;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb;
  logic [1:0]  out_wuser;
  logic        out_wlast;
  logic        out_mwvalid;
  logic        in_mwready;
  logic        out_busy;
`ifdef AXI_WDATA_TX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  axi_wdata_tx #(.CMD_DEPTH(DEPTH)) dut (
    .tx_clk      (tx_clk),
    .txreset     (txreset),
    .in_cid      (in_cid),
    .in_clen     (in_clen),
    .in_cuser    (in_cuser),
    .in_cvalid   (in_cvalid),
    .out_cready  (out_cready),
    .in_wdata    (in_wdata),
    .in_wstrb    (in_wstrb),
    .in_dvalid   (in_dvalid),
    .out_dready  (out_dready),
    .out_wid     (out_wid),
    .out_wdata   (out_wdata),
    .out_wstrb   (out_wstrb),
    .out_wuser   (out_wuser),
    .out_wlast   (out_wlast),
    .out_mwvalid (out_mwvalid),
    .in_mwready  (in_mwready),
    .out_busy    (out_busy)
`ifdef AXI_WDATA_TX_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int n_checks;
  int n_errors;
  int stall_model;

  typedef struct {
    logic        cvalid;
    logic [3:0]  cid;
    logic [3:0]  clen;
    logic [1:0]  cuser;
    logic        dvalid;
    logic [31:0] wdata;
    logic        mwready;
    logic        e_mwvalid;
    logic        e_wlast;
    logic [3:0]  e_wid;
    logic [1:0]  e_wuser;
    logic [31:0] e_wdata;
    logic        e_cready;
    logic        e_dready;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  vec_t        vecs [6];
  logic [3:0]  q_id   [$];
  logic [3:0]  q_len  [$];
  logic [1:0]  q_user [$];
  logic [31:0] q_data [$];
  logic [3:0]  q_strb [$];
  beat_t       exp_q  [$];
  int          hs_cyc [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_cvalid  = 1'b0;
    in_cid     = '0;
    in_clen    = '0;
    in_cuser   = '0;
    in_dvalid  = 1'b0;
    in_wdata   = '0;
    in_wstrb   = '0;
    in_mwready = 1'b1;
  endtask

  task automatic do_reset();
    txreset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge tx_clk);
    txreset = 1'b0;
    stall_model = 0;
  endtask

  task automatic clear_scn();
    q_id.delete();
    q_len.delete();
    q_user.delete();
    q_data.delete();
    q_strb.delete();
  endtask

  // Append a descriptor plus its len+1 data words (sequential or random).
  task automatic add_cmd(input logic [3:0] id, input logic [3:0] len, input logic [1:0] user,
                         input bit seq, input logic [31:0] base);
    q_id.push_back(id);
    q_len.push_back(len);
    q_user.push_back(user);
    for (int b = 0; b <= int'(len); b++) begin
      q_data.push_back(seq ? base + 32'(b) : 32'($urandom));
      q_strb.push_back(seq ? 4'hF : 4'($urandom));
    end
  endtask

  // Stream model: words are consumed in order, burst by burst.
  function automatic void build_expected();
    int k;
    beat_t bt;
    exp_q.delete();
    k = 0;
    for (int c = 0; c < q_id.size(); c++) begin
      for (int b = 0; b <= int'(q_len[c]); b++) begin
        bt.id   = q_id[c];
        bt.user = q_user[c];
        bt.data = q_data[k];
        bt.strb = q_strb[k];
        bt.last = (b == int'(q_len[c]));
        exp_q.push_back(bt);
        k++;
      end
    end
  endfunction

  // Drive the queued descriptors/words with the given valid and ready rates.
  task automatic run_traffic(input int ready_pct, input int valid_pct);
    int ci, di, bi, cyc;
    bit c_hs, d_hs, w_hs, stalled;
    logic [42:0] held, cur;
    build_expected();
    ci = 0; di = 0; bi = 0; cyc = 0;
    c_hs = 0; d_hs = 0; stalled = 0;
    held = '0;
    hs_cyc.delete();
    while ((bi < exp_q.size()) && (cyc < 3000)) begin
      @(negedge tx_clk);
      if (cyc == 0) begin
        in_cvalid = 1'b0;
        in_dvalid = 1'b0;
      end
      if (c_hs) begin ci++; in_cvalid = 1'b0; end
      if (d_hs) begin di++; in_dvalid = 1'b0; end
      if (!in_cvalid && (ci < q_id.size()) && ($urandom_range(99) < valid_pct)) begin
        in_cvalid = 1'b1;
        in_cid    = q_id[ci];
        in_clen   = q_len[ci];
        in_cuser  = q_user[ci];
      end
      if (!in_dvalid && (di < q_data.size()) && ($urandom_range(99) < valid_pct)) begin
        in_dvalid = 1'b1;
        in_wdata  = q_data[di];
        in_wstrb  = q_strb[di];
      end
      in_mwready = ($urandom_range(99) < ready_pct);
      #2;
      c_hs = in_cvalid & out_cready;
      d_hs = in_dvalid & out_dready;
      w_hs = out_mwvalid & in_mwready;
      cur  = {out_wid, out_wdata, out_wstrb, out_wuser, out_wlast};
      if (stalled) check("stall_hold", 64'(cur), 64'(held));
      if (out_mwvalid && !in_mwready) check("bp_dready", 64'(out_dready), 64'd0);
      if (w_hs) begin
        check("beat_id",   64'(out_wid),   64'(exp_q[bi].id));
        check("beat_data", 64'(out_wdata), 64'(exp_q[bi].data));
        check("beat_strb", 64'(out_wstrb), 64'(exp_q[bi].strb));
        check("beat_user", 64'(out_wuser), 64'(exp_q[bi].user));
        check("beat_last", 64'(out_wlast), 64'(exp_q[bi].last));
        hs_cyc.push_back(cyc);
        bi++;
      end
      stalled = out_mwvalid & ~in_mwready;
      if (stalled) begin
        stall_model++;
        held = cur;
      end
      cyc++;
    end
    if (bi < exp_q.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL traffic_timeout: got %0d beats expected %0d", bi, exp_q.size());
    end
    @(negedge tx_clk);
    if (c_hs) ci++;
    if (d_hs) di++;
    in_cvalid  = 1'b0;
    in_dvalid  = 1'b0;
    in_mwready = 1'b1;
    #2;
    check("cmds_used",      64'(ci), 64'(q_id.size()));
    check("words_used",     64'(di), 64'(q_data.size()));
    check("idle_mwvalid",   64'(out_mwvalid), 64'd0);
    check("busy_after_end", 64'(out_busy), 64'd0);
  endtask

  // With full throughput: back-to-back beats, one bubble only between bursts.
  task automatic check_gaps();
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check("beat_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), exp_q[i-1].last ? 64'd2 : 64'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    stall_model = 0;
    idle_inputs();
    txreset = 1'b1;

    // Reset values while held in reset.
    @(negedge tx_clk);
    #2;
    check("rst_mwvalid", 64'(out_mwvalid), 64'd0);
    check("rst_wlast",   64'(out_wlast),   64'd0);
    check("rst_wid",     64'(out_wid),     64'd0);
    check("rst_wdata",   64'(out_wdata),   64'd0);
    check("rst_wstrb",   64'(out_wstrb),   64'd0);
    check("rst_wuser",   64'(out_wuser),   64'd0);
    check("rst_dready",  64'(out_dready),  64'd0);
    check("rst_cready",  64'(out_cready),  64'd0);
    check("rst_busy",    64'(out_busy),    64'd0);
`ifdef AXI_WDATA_TX_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge tx_clk);
    txreset = 1'b0;

    // Single-beat burst id=3 len=0 user=2, with one stall cycle on the beat.
    vecs[0] = '{1'b1, 4'd3, 4'd0, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'd3, 2'd2, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 4'd3, 2'd2, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 4'd3, 2'd2, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge tx_clk);
      in_cvalid  = vecs[i].cvalid;
      in_cid     = vecs[i].cid;
      in_clen    = vecs[i].clen;
      in_cuser   = vecs[i].cuser;
      in_dvalid  = vecs[i].dvalid;
      in_wdata   = vecs[i].wdata;
      in_wstrb   = 4'hF;
      in_mwready = vecs[i].mwready;
      #2;
      check("vec_mwvalid", 64'(out_mwvalid), 64'(vecs[i].e_mwvalid));
      check("vec_wlast",   64'(out_wlast),   64'(vecs[i].e_wlast));
      check("vec_wid",     64'(out_wid),     64'(vecs[i].e_wid));
      check("vec_wuser",   64'(out_wuser),   64'(vecs[i].e_wuser));
      check("vec_wdata",   64'(out_wdata),   64'(vecs[i].e_wdata));
      check("vec_cready",  64'(out_cready),  64'(vecs[i].e_cready));
      check("vec_dready",  64'(out_dready),  64'(vecs[i].e_dready));
      check("vec_busy",    64'(out_busy),    64'(vecs[i].e_busy));
    end

    // 16-beat burst, full throughput.
    clear_scn();
    add_cmd(4'd7, 4'd15, 2'd1, 1'b1, 32'h0);
    run_traffic(100, 100);
    check_gaps();

    // Two queued bursts: 4 beats id=1, bubble, 2 beats id=2.
    clear_scn();
    add_cmd(4'd1, 4'd3, 2'd0, 1'b1, 32'h100);
    add_cmd(4'd2, 4'd1, 2'd3, 1'b1, 32'h200);
    run_traffic(100, 100);
    check_gaps();

    // Randomized traffic from a clean reset, stall cycles tracked.
    do_reset();
    clear_scn();
    add_cmd(4'd6, 4'd7, 2'd1, 1'b0, 32'h0);
    run_traffic(50, 100);
    for (int r = 0; r < 4; r++) begin
      int n;
      clear_scn();
      n = int'($urandom_range(6, 2));
      for (int c = 0; c < n; c++) begin
        add_cmd(4'($urandom), 4'($urandom), 2'($urandom), 1'b0, 32'h0);
      end
      run_traffic(int'($urandom_range(90, 30)), int'($urandom_range(100, 40)));
    end
`ifdef AXI_WDATA_TX_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif

    // Fill the FIFO with no data; one entry is popped into the FSM.
    in_mwready = 1'b1;
    in_dvalid  = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      @(negedge tx_clk);
      in_cvalid = 1'b1;
      in_cid    = 4'(i + 4);
      in_clen   = 4'd3;
      in_cuser  = 2'(i);
      #2;
      check("fill_cready", 64'(out_cready), 64'd1);
    end
    @(negedge tx_clk);
    #2;
    check("full_cready", 64'(out_cready), 64'd0);
    check("full_busy",   64'(out_busy),   64'd1);

    // Start the first burst (id 4, 4 beats), then reset on beat 2.
    @(negedge tx_clk);
    in_cvalid = 1'b0;
    in_dvalid = 1'b1;
    in_wdata  = 32'hD000_0000;
    in_wstrb  = 4'hF;
    #2;
    check("b0_dready", 64'(out_dready), 64'd1);
    @(negedge tx_clk);
    in_wdata = 32'hD000_0001;
    #2;
    check("b0_mwvalid", 64'(out_mwvalid), 64'd1);
    check("b0_wid",     64'(out_wid),     64'd4);
    check("b0_wdata",   64'(out_wdata),   64'hD000_0000);
    check("b0_wlast",   64'(out_wlast),   64'd0);
    @(negedge tx_clk);
    in_wdata = 32'hD000_0002;
    #2;
    check("b1_wdata", 64'(out_wdata), 64'hD000_0001);
    txreset = 1'b1;
    #1;
    check("mid_rst_mwvalid", 64'(out_mwvalid), 64'd0);
    check("mid_rst_wlast",   64'(out_wlast),   64'd0);
    check("mid_rst_wid",     64'(out_wid),     64'd0);
    check("mid_rst_wdata",   64'(out_wdata),   64'd0);
    check("mid_rst_wstrb",   64'(out_wstrb),   64'd0);
    check("mid_rst_wuser",   64'(out_wuser),   64'd0);
    check("mid_rst_dready",  64'(out_dready),  64'd0);
    check("mid_rst_cready",  64'(out_cready),  64'd0);
    check("mid_rst_busy",    64'(out_busy),    64'd0);
    @(negedge tx_clk);
    txreset = 1'b0;
    stall_model = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge tx_clk);
      #2;
      check("post_rst_mwvalid", 64'(out_mwvalid), 64'd0);
      check("post_rst_busy",    64'(out_busy),    64'd0);
      check("post_rst_dready",  64'(out_dready),  64'd0);
      check("post_rst_cready",  64'(out_cready),  64'd1);
    end

    // A fresh descriptor after reset runs normally.
    clear_scn();
    add_cmd(4'd9, 4'd1, 2'd3, 1'b1, 32'hE0);
    run_traffic(100, 100);
    check_gaps();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
